// File: rtl/aud_pkg.sv
// aud_pkg: shared definitions for the audio pipeline (DSP, recorder, player).
//   SAMPLE_W     - PCM sample width in bits
//   BITCNT_W     - width of the serialiser bit counter
//   sample_t     - one PCM sample
//   bitcnt_t     - serialiser bit index
//   play_state_t - I2S player FSM states
package aud_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned BITCNT_W = 4;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [BITCNT_W-1:0] bitcnt_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SEND,
        PAD
    } play_state_t;

endpackage

// File: rtl/aud_player_lrck_edge.sv
// lrck_edge: registers the codec DAC LR clock and flags its edges.
//   i_clk   - bit clock
//   i_rst_n - asynchronous active-low reset
//   i_lrck  - DAC LR clock (low = left, high = right)
//   o_fall  - i_lrck is low while the registered copy is high (left frame start)
//   o_rise  - i_lrck is high while the registered copy is low (right frame start)
module lrck_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_lrck,
    output logic o_fall,
    output logic o_rise
);

    logic lrck_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lrck_d <= 1'b0;
        end else begin
            lrck_d <= i_lrck;
        end
    end

    // Edges are combinational against the registered copy so the word can be
    // loaded in the same cycle the change is first seen.
    assign o_fall = lrck_d & ~i_lrck;
    assign o_rise = ~lrck_d & i_lrck;

endmodule

// File: rtl/aud_player.sv
// aud_player: I2S serialiser driving mono PCM to both codec DAC channels.
//   i_clk            - codec bit clock, all logic on its rising edge
//   i_rst_n          - asynchronous active-low reset
//   i_en             - playback enable
//   i_daclrck        - codec DAC LR clock (low = left, high = right)
//   i_dac_data       - PCM sample from the DSP stage
//   i_dac_data_ready - i_dac_data valid this cycle
//   o_aud_dacdat     - serial data to the codec, MSB first
//   o_busy           - high while a channel word is being shifted out
//   o_underrun       - sticky: a left frame started without a fresh sample
module aud_player
    import aud_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic                i_daclrck,
    input  logic [SAMPLE_W-1:0] i_dac_data,
    input  logic                i_dac_data_ready,
    output logic                o_aud_dacdat,
    output logic                o_busy,
    output logic                o_underrun
);

    logic        fall;
    logic        rise;
    logic        edge_det;

    play_state_t state;
    play_state_t state_nxt;

    sample_t     pending;
    logic        pending_valid;
    sample_t     last_sample;
    sample_t     shreg;
    bitcnt_t     bit_cnt;
    logic        en_d;

    logic        load;
    logic        bypass;
    logic        use_pending;
    logic        underrun_set;
    logic        shifting;
    sample_t     load_word;
    logic        dacdat_nxt;
    logic        busy_nxt;

    lrck_edge u_lrck_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_lrck  (i_daclrck),
        .o_fall  (fall),
        .o_rise  (rise)
    );

    assign edge_det = fall | rise;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (!i_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      state_nxt = WAIT;
                WAIT, PAD: if (edge_det) state_nxt = SEND;
                SEND:      if (!edge_det && bit_cnt == '0) state_nxt = PAD;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    // Output / datapath control
    always_comb begin
        load         = i_en && (state != IDLE) && edge_det;
        bypass       = load && fall && i_dac_data_ready;
        use_pending  = load && fall && !i_dac_data_ready && pending_valid;
        underrun_set = load && fall && !i_dac_data_ready && !pending_valid;
        shifting     = i_en && (state == SEND) && !edge_det && (bit_cnt != '0);

        // Right frames and starved left frames replay last_sample.
        load_word = last_sample;
        if (bypass) begin
            load_word = i_dac_data;
        end else if (use_pending) begin
            load_word = pending;
        end

        dacdat_nxt = 1'b0;
        busy_nxt   = 1'b0;
        if (load) begin
            dacdat_nxt = load_word[SAMPLE_W-1];
            busy_nxt   = 1'b1;
        end else if (shifting) begin
            dacdat_nxt = shreg[SAMPLE_W-1];
            busy_nxt   = 1'b1;
        end
    end

    // Shift register holds the bits still to be sent; bit_cnt counts them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shreg        <= '0;
            bit_cnt      <= '0;
            o_aud_dacdat <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_aud_dacdat <= dacdat_nxt;
            o_busy       <= busy_nxt;
            if (load) begin
                shreg   <= {load_word[SAMPLE_W-2:0], 1'b0};
                bit_cnt <= '1;
            end else if (shifting) begin
                shreg   <= {shreg[SAMPLE_W-2:0], 1'b0};
                bit_cnt <= bit_cnt - 1'b1;
            end
        end
    end

    // Sample buffering: a sample arriving on the left-load cycle is consumed
    // directly and never marked pending.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending       <= '0;
            pending_valid <= 1'b0;
            last_sample   <= '0;
        end else begin
            if (i_dac_data_ready) begin
                pending       <= i_dac_data;
                pending_valid <= !bypass;
            end else if (use_pending) begin
                pending_valid <= 1'b0;
            end

            if (bypass) begin
                last_sample <= i_dac_data;
            end else if (use_pending) begin
                last_sample <= pending;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            en_d       <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            en_d <= i_en;
            if (i_en && !en_d) begin
                o_underrun <= 1'b0;
            end else if (underrun_set) begin
                o_underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aud_player.sv
// tb_aud_player: checks aud_player against a queue-based model of the I2S
// player, plus directed scenarios with hand-computed expectations.
module tb_aud_player;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        en    = 1'b0;
    logic        lrck  = 1'b0;
    logic        ready = 1'b0;
    logic [15:0] data  = '0;
    logic        dacdat;
    logic        busy;
    logic        underrun;

    int n_vec = 0;
    int n_err = 0;
    bit check_on = 1'b0;

    always #5 clk = ~clk;

    aud_player dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_en             (en),
        .i_daclrck        (lrck),
        .i_dac_data       (data),
        .i_dac_data_ready (ready),
        .o_aud_dacdat     (dacdat),
        .o_busy           (busy),
        .o_underrun       (underrun)
    );

    // ---------------- behavioural model ----------------
    bit          m_armed   = 1'b0;
    bit          m_lr_prev = 1'b0;
    bit          m_en_prev = 1'b0;
    bit          m_pv      = 1'b0;
    bit          m_under   = 1'b0;
    logic [15:0] m_pend    = '0;
    logic [15:0] m_last    = '0;
    bit          m_bits[$];
    logic        m_dat     = 1'b0;
    logic        m_busy    = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        bit          fall_e;
        bit          rise_e;
        bit          took;
        logic [15:0] w;
        if (!rst_n) begin
            m_armed = 0; m_lr_prev = 0; m_en_prev = 0; m_pv = 0; m_under = 0;
            m_pend = '0; m_last = '0; m_bits.delete(); m_dat = 0; m_busy = 0;
        end else begin
            fall_e = m_lr_prev && !lrck;
            rise_e = !m_lr_prev && lrck;
            took   = 0;
            w      = m_last;
            if (en && !m_en_prev) m_under = 0;
            if (!en) begin
                m_armed = 0;
                m_bits.delete();
            end else if (!m_armed) begin
                m_armed = 1;
            end else if (fall_e || rise_e) begin
                if (rise_e) begin
                    w = m_last;
                end else if (ready) begin
                    w = data; m_last = data; m_pv = 0; took = 1;
                end else if (m_pv) begin
                    w = m_pend; m_last = m_pend; m_pv = 0;
                end else begin
                    w = m_last; m_under = 1;
                end
                m_bits.delete();
                for (int i = 15; i >= 0; i--) m_bits.push_back(w[i]);
            end
            if (ready && !took) begin
                m_pend = data; m_pv = 1;
            end
            if (m_bits.size() > 0) begin
                m_dat = m_bits.pop_front(); m_busy = 1;
            end else begin
                m_dat = 0; m_busy = 0;
            end
            m_lr_prev = lrck;
            m_en_prev = en;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_on) begin
            chk("model_dacdat", {15'd0, dacdat}, {15'd0, m_dat});
            chk("model_busy", {15'd0, busy}, {15'd0, m_busy});
            chk("model_underrun", {15'd0, underrun}, {15'd0, m_under});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ready_pulse(input logic [15:0] v);
        ready = 1; data = v;
        tick();
        ready = 0;
    endtask

    // Drive one LRCK half-period of len cycles, capturing the first 16 bits.
    task automatic play(input bit lvl, input int len, output logic [15:0] w, output int busy_cnt);
        w = '0;
        busy_cnt = 0;
        lrck = lvl;
        for (int i = 0; i < 16; i++) begin
            tick();
            ready = 0;
            w = {w[14:0], dacdat};
            if (busy) busy_cnt++;
        end
        for (int i = 16; i < len; i++) tick();
    endtask

    logic [15:0] w;
    int          bc;
    int          bc2;
    int          cnt;
    int          half;

    initial begin
        #1 rst_n = 0;
        check_on = 1;
        tick(); tick();
        chk("reset_dacdat", {15'd0, dacdat}, 16'h0000);
        chk("reset_busy", {15'd0, busy}, 16'h0000);
        chk("reset_underrun", {15'd0, underrun}, 16'h0000);
        rst_n = 1;
        tick();
        en = 1;
        tick(); tick();

        // Basic left/right playback of one sample
        play(1'b1, 20, w, bc);
        ready_pulse(16'hA5C3);
        play(1'b0, 16, w, bc);
        chk("left_word", w, 16'hA5C3);
        chk("left_busy_cycles", bc[15:0], 16'd16);
        tick();
        chk("pad_dacdat", {15'd0, dacdat}, 16'h0000);
        chk("pad_busy", {15'd0, busy}, 16'h0000);
        tick(); tick();
        play(1'b1, 20, w, bc);
        chk("right_repeat", w, 16'hA5C3);
        chk("no_underrun", {15'd0, underrun}, 16'h0000);

        // Last write in a frame wins
        ready_pulse(16'h1234);
        tick();
        ready_pulse(16'h8001);
        play(1'b0, 20, w, bc);
        chk("last_write_wins", w, 16'h8001);
        chk("lww_underrun", {15'd0, underrun}, 16'h0000);

        // Starved left frame repeats last sample and flags underrun
        play(1'b1, 18, w, bc);
        ready_pulse(16'h7FFF);
        play(1'b0, 20, w, bc);
        chk("pre_underrun_word", w, 16'h7FFF);
        play(1'b1, 20, w, bc);
        play(1'b0, 20, w, bc);
        chk("underrun_word", w, 16'h7FFF);
        chk("underrun_set", {15'd0, underrun}, 16'h0001);
        play(1'b1, 20, w, bc);
        chk("underrun_sticky", {15'd0, underrun}, 16'h0001);
        en = 0;
        tick();
        en = 1;
        tick();
        chk("underrun_cleared", {15'd0, underrun}, 16'h0000);
        tick();

        // Sample arriving in the falling-edge cycle goes straight out
        ready = 1; data = 16'hFFFF;
        play(1'b0, 20, w, bc);
        chk("bypass_word", w, 16'hFFFF);
        chk("bypass_underrun", {15'd0, underrun}, 16'h0000);

        // Short right frame aborted after 8 SEND cycles
        lrck = 1; ready = 1; data = 16'h0F0F;
        bc2 = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            ready = 0;
            if (busy) bc2++;
        end
        play(1'b0, 20, w, bc);
        chk("abort_word", w, 16'h0F0F);
        chk("abort_busy_cont", bc2[15:0] + bc[15:0], 16'd24);

        // Reset mid-word
        ready_pulse(16'hC0DE);
        lrck = 1;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 0;
        #1;
        chk("rst_mid_dacdat", {15'd0, dacdat}, 16'h0000);
        chk("rst_mid_busy", {15'd0, busy}, 16'h0000);
        tick();
        rst_n = 1;
        for (int i = 0; i < 4; i++) tick();
        chk("rst_quiet", {15'd0, dacdat | busy}, 16'h0000);
        play(1'b0, 20, w, bc);
        chk("post_rst_word", w, 16'h0000);

        // Enable dropped mid-word
        ready_pulse(16'hFFFF);
        lrck = 1;
        for (int i = 0; i < 4; i++) tick();
        en = 0;
        tick();
        chk("en_drop_dacdat", {15'd0, dacdat}, 16'h0000);
        chk("en_drop_busy", {15'd0, busy}, 16'h0000);
        en = 1;
        for (int i = 0; i < 4; i++) tick();
        chk("en_quiet", {15'd0, dacdat | busy}, 16'h0000);
        play(1'b0, 20, w, bc);
        chk("en_resume_word", w, 16'hFFFF);

        // Randomised traffic against the model
        cnt  = 0;
        half = 20;
        for (int c = 0; c < 4000; c++) begin
            ready = 0;
            if (cnt >= half) begin
                lrck = ~lrck;
                cnt  = 0;
                half = int'($urandom_range(30, 6));
            end else begin
                cnt++;
            end
            if ($urandom_range(15, 0) == 0) begin
                ready = 1;
                data  = 16'($urandom);
            end
            if (en && $urandom_range(399, 0) == 0) en = 0;
            else if (!en && $urandom_range(7, 0) == 0) en = 1;
            rst_n = ($urandom_range(1499, 0) != 0);
            tick();
        end
        rst_n = 1;
        ready = 0;
        tick(); tick();

        check_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aud_player.md
AUD_PLAYER -- requirements
Module: aud_player

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: the only clock, the codec bit clock (AUD_BCLK); all logic runs on its rising edge.
REQ-002 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have port i_en, input, 1 bit: playback enable.
REQ-004 SHALL have port i_daclrck, input, 1 bit: codec DAC LR clock; low = left channel, high = right channel.
REQ-005 SHALL have port i_dac_data, input, 16 bits: signed PCM sample from the DSP stage.
REQ-006 SHALL have port i_dac_data_ready, input, 1 bit: i_dac_data is valid this cycle.
REQ-007 SHALL have port o_aud_dacdat, output, 1 bit: serial I2S data to the codec.
REQ-008 SHALL have port o_busy, output, 1 bit: high while a channel word is being shifted out.
REQ-009 SHALL have port o_underrun, output, 1 bit: sticky flag; a left frame started with no fresh sample.

Function
REQ-010 SHALL register i_daclrck into lrck_d every cycle; an edge is detected in any cycle where i_daclrck != lrck_d.
REQ-011 SHALL capture i_dac_data into a pending register and set pending_valid in every cycle where i_dac_data_ready=1, regardless of state. The last write in a frame wins.
REQ-012 SHALL implement FSM states IDLE, WAIT, SEND, PAD.
REQ-013 IDLE: o_aud_dacdat=0 and o_busy=0; go to WAIT when i_en=1.
REQ-014 WAIT: go to SEND on a detected edge, loading the shift register in that same cycle.
REQ-015 On a falling edge (left frame), the shift register SHALL load pending if pending_valid=1, then clear pending_valid and copy the value to last_sample. Otherwise it SHALL load last_sample and set o_underrun.
REQ-016 On a rising edge (right frame), the shift register SHALL load last_sample, so the output is mono duplicated to both channels.
REQ-017 SHALL drive the MSB (bit 15) registered on the edge-detect cycle. This places the MSB on the 2nd rising BCLK after the LRCK change, per I2S.
REQ-018 SHALL drive bits 14..0 on the following 15 cycles, MSB-first, using a 4-bit bit counter. o_busy=1 for exactly these 16 cycles.
REQ-019 After bit 0, SHALL enter PAD with o_aud_dacdat=0 until the next edge. That edge re-enters SEND by the REQ-014/015/016 rules.
REQ-020 An edge detected while in SEND SHALL abort the current word and reload per REQ-015/016 in the same cycle; this covers short frames and edge resync.
REQ-021 i_en=0 in any state SHALL force IDLE at the next edge of i_clk, with o_aud_dacdat=0 and o_busy=0; pending and last_sample are retained.
REQ-022 A simultaneous i_dac_data_ready and falling edge SHALL load the incoming i_dac_data directly, bypassing pending, with no underrun.
REQ-023 o_underrun SHALL clear only on reset or on a rising edge of i_en.
REQ-024 The serialiser SHALL not alter sample values; there is no arithmetic on the data path.

Reset
REQ-025 On i_rst_n=0, SHALL immediately set: state=IDLE, o_aud_dacdat=0, o_busy=0, o_underrun=0, lrck_d=0, pending=0, pending_valid=0, last_sample=0, bit counter=0, shift register=0.
REQ-026 Reset asserted mid-word SHALL truncate the word. After release, output SHALL stay 0 until the first detected edge with i_en=1.

Structure
REQ-027 The FSM state enum, the sample width (16) and the bit-counter width SHALL live in the shared package aud_pkg, used also by the DSP and recorder stages.
REQ-028 The LRCK edge detector SHALL be a sub-module, lrck_edge, with outputs o_fall and o_rise; everything else is flat.

Verification
REQ-029 i_en=1, ready pulse with 16'hA5C3 before a falling LRCK edge -> dacdat at the edge cycle and next 15 cycles = 1010_0101_1100_0011, then 0; the right frame repeats 16'hA5C3.
REQ-030 Ready with 16'h1234, then 16'h8001 in the same frame -> the next left word is 16'h8001; o_underrun stays 0.
REQ-031 No ready before a falling edge after 16'h7FFF was played -> left word = 16'h7FFF, o_underrun=1 and stays 1 until i_en toggles.
REQ-032 Ready with 16'hFFFF in the exact falling-edge cycle -> that word goes out immediately; o_underrun=0.
REQ-033 LRCK toggled after 8 SEND cycles -> the word aborts and the new MSB appears in the edge cycle; o_busy stays high continuously.
REQ-034 i_rst_n pulsed low mid-word, and i_en dropped mid-word in a separate run -> o_aud_dacdat=0 and o_busy=0 immediately (reset) or next cycle (i_en); output resumes only at the next edge.
